axi_log_drainer: RTL and testbench



---
 rtl/axi_log_drainer_pkg.sv | 13 +
 rtl/bram_port.sv | 12 +
 rtl/axi_log_drainer_unpack.sv | 22 ++
 rtl/axi_log_drainer.sv | 124 ++++++++++++
 tb/tb_axi_log_drainer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/axi_log_drainer_pkg.sv
// axi_log_drainer_pkg: shared entry layout, capacity helper and FSM states for the log drainer
package axi_log_drainer_pkg;
  localparam int unsigned ENTRY_WORDS = 3;
  localparam int unsigned WORD_BITW = 32;
  localparam int unsigned TS_WORD = 0;
  localparam int unsigned ADDR_WORD = 1;
  localparam int unsigned IDLEN_WORD = 2;
  localparam int unsigned ID_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_WAIT, S_OUT, S_DONE} state_t;
  function automatic int unsigned log_cap(input int unsigned n);
    return 1024 * n;
  endfunction
endpackage

// File: rtl/bram_port.sv
// bram_port: single-port BRAM connection, 32-bit data and byte address
interface bram_port;
  logic        Clk_C;
  logic        Rst_R;
  logic        En_S;
  logic [31:0] Addr_S;
  logic [31:0] Rd_D;
  logic [31:0] Wr_D;
  logic [3:0]  WrEn_S;
  modport master(output Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S, input Rd_D);
  modport slave(input Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S, output Rd_D);
endinterface

// File: rtl/axi_log_drainer_unpack.sv
// axi_log_entry_unpack: combinational split of a three-word log entry into its fields
module axi_log_entry_unpack
  import axi_log_drainer_pkg::*;
#(
  parameter int TIMESTAMP_BITW = 32,
  parameter int AXI_ADDR_BITW  = 32,
  parameter int AXI_ID_BITW    = 8,
  parameter int AXI_LEN_BITW   = 8
) (
  input  logic [ENTRY_WORDS-1:0][WORD_BITW-1:0] words_di,
  output logic [TIMESTAMP_BITW-1:0]             timestamp_do,
  output logic [AXI_ADDR_BITW-1:0]              addr_do,
  output logic [AXI_ID_BITW-1:0]                id_do,
  output logic [AXI_LEN_BITW-1:0]               len_do,
  output logic                                  zero_so
);
  assign timestamp_do = words_di[TS_WORD][TIMESTAMP_BITW-1:0];
  assign addr_do      = words_di[ADDR_WORD][AXI_ADDR_BITW-1:0];
  assign id_do        = words_di[IDLEN_WORD][ID_LSB +: AXI_ID_BITW];
  assign len_do       = words_di[IDLEN_WORD][ID_LSB+AXI_ID_BITW +: AXI_LEN_BITW];
  assign zero_so      = ~|words_di;
endmodule

// File: rtl/axi_log_drainer.sv
// axi_log_drainer: reads three-word log entries from BRAM and streams them out over a valid/ready handshake
module axi_log_drainer
  import axi_log_drainer_pkg::*;
#(
  parameter int NUM_SER_BRAMS  = 12,
  parameter int TIMESTAMP_BITW = 32,
  parameter int AXI_ADDR_BITW  = 32,
  parameter int AXI_ID_BITW    = 8,
  parameter int AXI_LEN_BITW   = 8,
  localparam int CAP   = log_cap(NUM_SER_BRAMS),
  localparam int CNT_W = $clog2(CAP) + 1
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      Start_SI,
  input  logic                      Abort_SI,
  input  logic [CNT_W-1:0]          EntryLimit_DI,
  input  logic                      ClearOnDone_SI,
  output logic                      Busy_SO,
  output logic                      Done_SO,
  output logic                      ClearLog_SO,
  output logic [CNT_W-1:0]          EntryCnt_DO,
  output logic                      Valid_SO,
  input  logic                      Ready_SI,
  output logic [TIMESTAMP_BITW-1:0] Timestamp_DO,
  output logic [AXI_ADDR_BITW-1:0]  Addr_DO,
  output logic [AXI_ID_BITW-1:0]    Id_DO,
  output logic [AXI_LEN_BITW-1:0]   Len_DO,
  bram_port.master                  Bram_PM
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, lim_q, lim_d;
  logic [WORD_BITW-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, w2_cur;
  logic [1:0] k;
  logic hs, last, zero;
  assign Bram_PM.Clk_C  = Clk_CI;
  assign Bram_PM.Rst_R  = ~Rst_RBI;
  assign Bram_PM.Wr_D   = '0;
  assign Bram_PM.WrEn_S = '0;
  assign EntryCnt_DO    = idx_q;
  assign w2_cur         = state_q == S_WAIT ? Bram_PM.Rd_D : w2_q;
  axi_log_entry_unpack #(
    .TIMESTAMP_BITW(TIMESTAMP_BITW),
    .AXI_ADDR_BITW (AXI_ADDR_BITW),
    .AXI_ID_BITW   (AXI_ID_BITW),
    .AXI_LEN_BITW  (AXI_LEN_BITW)
  ) u_unpack (
    .words_di    ({w2_cur, w1_q, w0_q}),
    .timestamp_do(Timestamp_DO),
    .addr_do     (Addr_DO),
    .id_do       (Id_DO),
    .len_do      (Len_DO),
    .zero_so     (zero)
  );
  // status, handshake and BRAM read-port outputs decoded from the current state
  always_comb begin
    Busy_SO        = state_q != S_IDLE;
    Valid_SO       = state_q == S_OUT && !Abort_SI;
    Done_SO        = state_q == S_DONE && !Abort_SI;
    ClearLog_SO    = Done_SO && ClearOnDone_SI;
    hs             = Valid_SO && Ready_SI;
    last           = idx_q + CNT_W'(1) == lim_q || idx_q + CNT_W'(1) == CNT_W'(CAP);
    k              = state_q == S_RD2 ? 2'd2 : {1'b0, state_q == S_RD1};
    Bram_PM.En_S   = state_q == S_RD0 || state_q == S_RD1 || state_q == S_RD2;
    Bram_PM.Addr_S = (32'(idx_q) * ENTRY_WORDS + 32'(k)) << 2;
  end
  // next state, entry index and word capture; abort overrides everything
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    case (state_q)
      S_IDLE: if (Start_SI) begin
        state_d = S_RD0;
        idx_d   = '0;
        lim_d   = EntryLimit_DI == '0 ? CNT_W'(CAP) : EntryLimit_DI;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        state_d = S_RD2;
        w0_d    = Bram_PM.Rd_D;
      end
      S_RD2: begin
        state_d = S_WAIT;
        w1_d    = Bram_PM.Rd_D;
      end
      S_WAIT: begin
        state_d = zero ? S_DONE : S_OUT;
        w2_d    = Bram_PM.Rd_D;
      end
      S_OUT: if (hs) begin
        state_d = last ? S_DONE : S_RD0;
        idx_d   = idx_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (Abort_SI) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      lim_d   = lim_q;
    end
  end
  // state and datapath registers
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lim_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
    end
  end
endmodule

// File: tb/tb_axi_log_drainer.sv
// tb_axi_log_drainer: directed checks of the log drainer against a BRAM model
module tb_axi_log_drainer;
  import axi_log_drainer_pkg::*;
  localparam int CAP = 1024;
  localparam int CW  = 11;
  localparam int NW  = 3 * CAP;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, clr_on = 0, ready = 0;
  logic [CW-1:0] lim = '0, cnt;
  logic busy, done, clrlog, valid;
  logic [31:0] ts, addr;
  logic [7:0] id, len;
  logic [31:0] mem [0:NW-1];
  logic [31:0] bram_rd = '0;
  logic [2:0][31:0] uw = '0;
  logic [31:0] u_ts, u_addr;
  logic [7:0] u_id, u_len;
  logic u_zero;
  int total = 0, bad = 0;
  int hs = 0, done_n = 0, clr_n = 0, clr_same = 0, cyc = 0;
  int first_v = -1, first_addr = -1, last_addr = 0, max_addr = 0;
  bram_port bram();
  always #5 clk = ~clk;
  axi_log_drainer #(.NUM_SER_BRAMS(1)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Abort_SI(abort),
    .EntryLimit_DI(lim), .ClearOnDone_SI(clr_on), .Busy_SO(busy), .Done_SO(done),
    .ClearLog_SO(clrlog), .EntryCnt_DO(cnt), .Valid_SO(valid), .Ready_SI(ready),
    .Timestamp_DO(ts), .Addr_DO(addr), .Id_DO(id), .Len_DO(len), .Bram_PM(bram)
  );
  axi_log_entry_unpack u_unp (
    .words_di(uw), .timestamp_do(u_ts), .addr_do(u_addr), .id_do(u_id), .len_do(u_len), .zero_so(u_zero)
  );
  assign bram.Rd_D = bram_rd;
  always @(posedge clk) if (bram.En_S) bram_rd <= mem[bram.Addr_S[13:2]];
  function automatic logic [95:0] gen(input int e);
    logic [7:0] b;
    b = e[7:0];
    return {16'h0, b ^ 8'h5A, b, 32'hA000_0000 | 32'(e << 4), 32'h1000_0000 + 32'(e)};
  endfunction
  function automatic logic [79:0] exp_fields(input int e);
    logic [7:0] b;
    b = e[7:0];
    return {32'h1000_0000 + 32'(e), 32'hA000_0000 | 32'(e << 4), b, b ^ 8'h5A};
  endfunction
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < CAP; i++) {mem[3*i+2], mem[3*i+1], mem[3*i]} = i < n ? gen(i) : '0;
  endtask
  task automatic begin_drain(input int l, input bit c);
    lim = CW'(l);
    clr_on = c;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy; n++) @(negedge clk);
    if (busy) check("timeout", busy, 0);
    @(negedge clk);
  endtask
  task automatic run(input int l, input bit c, input int budget);
    begin_drain(l, c);
    wait_idle(budget);
  endtask
  initial forever begin
    @(negedge clk);
    if (start && !busy) begin
      hs = 0; done_n = 0; clr_n = 0; clr_same = 0; cyc = 0;
      first_v = -1; first_addr = -1; last_addr = 0; max_addr = 0;
    end else cyc++;
    if (valid && first_v < 0) first_v = cyc;
    if (bram.En_S) begin
      if (first_addr < 0) first_addr = int'(bram.Addr_S);
      last_addr = int'(bram.Addr_S);
      if (last_addr > max_addr) max_addr = last_addr;
    end
    if (valid && ready) begin
      check("fields", {ts, addr, id, len}, exp_fields(hs));
      hs++;
    end
    if (done) done_n++;
    if (clrlog) clr_n++;
    if (done && clrlog) clr_same++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", {valid, busy, done, clrlog, bram.En_S, cnt}, 0);
    check("rst_bram", {bram.Rst_R, bram.WrEn_S, bram.Wr_D}, {1'b1, 4'h0, 32'h0});
    uw = {32'h0000_A55A, 32'h1234_5678, 32'hDEAD_BEEF};
    #1 check("unpack", {u_ts, u_addr, u_id, u_len, u_zero}, {32'hDEAD_BEEF, 32'h1234_5678, 8'h5A, 8'hA5, 1'b0});
    uw = '0;
    #1 check("unpack_zero", u_zero, 1);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 check("bram_clk_rst", {bram.Clk_C, bram.Rst_R}, 2'b10);
    fill(4);
    ready = 1;
    run(0, 0, 200);
    check("t1_hs", hs, 4);
    check("t1_first_valid", first_v, 5);
    check("t1_done", done_n, 1);
    check("t1_cnt", cnt, 4);
    check("t1_max_addr", max_addr, 32'h38);
    check("t1_clr", clr_n, 0);
    fill(4);
    {mem[8], mem[7], mem[6]} = '0;
    run(0, 0, 200);
    check("t2_hs", hs, 2);
    check("t2_done", done_n, 1);
    check("t2_cnt", cnt, 2);
    check("t2_max_addr", max_addr, 32'h20);
    fill(10);
    run(3, 0, 200);
    check("t3_hs", hs, 3);
    check("t3_cnt", cnt, 3);
    check("t3_last_addr", last_addr, 32'h20);
    check("t3_done", done_n, 1);
    fill(4);
    ready = 0;
    begin_drain(0, 0);
    for (int n = 0; n < 20 && !valid; n++) @(negedge clk);
    check("t4_valid", valid, 1);
    repeat (7) begin
      @(negedge clk);
      check("t4_stall", {valid, bram.En_S, ts, addr, id, len}, {1'b1, 1'b0, exp_fields(0)});
    end
    @(posedge clk); #1 ready = 1;
    wait_idle(200);
    check("t4_hs", hs, 4);
    check("t4_done", done_n, 1);
    begin_drain(0, 0);
    for (int n = 0; n < 40 && !(bram.En_S && bram.Addr_S == 32'h10); n++) @(negedge clk);
    check("t5_rd1_e1", {bram.En_S, bram.Addr_S}, {1'b1, 32'h10});
    abort = 1;
    @(posedge clk); #1 abort = 0;
    check("t5_idle", {busy, valid}, 0);
    @(negedge clk);
    check("t5_no_done", {done_n[7:0], clr_n[7:0]}, 0);
    check("t5_cnt", cnt, 1);
    run(0, 0, 200);
    check("t5_restart_addr", first_addr, 0);
    check("t5_hs", hs, 4);
    check("t5_done", done_n, 1);
    fill(CAP);
    run(0, 1, 6000);
    check("t6_hs", hs, CAP);
    check("t6_cnt", cnt, CAP);
    check("t6_done", done_n, 1);
    check("t6_clr_same", clr_same, 1);
    check("t6_clr_total", clr_n, 1);
    check("t6_max_addr", max_addr, 32'h2FFC);
    fill(4);
    begin_drain(0, 0);
    for (int n = 0; n < 20 && !valid; n++) @(negedge clk);
    rst_n = 0;
    #1 check("t7_rst_mid", {valid, busy, done, clrlog, bram.En_S, cnt}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("t7_after", {valid, busy, cnt}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
